// File: rtl/mod_mon_pkg.sv
// Shared types and helpers for the mod-N counter monitor.
// Holds the FSM state encoding, default parameter values and the successor function.
package mod_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } mon_state_t;

    localparam int MOD_DEF    = 5;
    localparam int CW_DEF     = 3;
    localparam int STABLE_DEF = 2;

    // Expected successor of a count in a modulo-`modulus` sequence.
    function automatic int unsigned next_count(input int unsigned v, input int unsigned modulus);
        return (v + 1) % modulus;
    endfunction

endpackage

// File: rtl/cnt_sync_filter.sv
// Two-flop resynchroniser for the ripple counter bus followed by a stability filter.
// A value is accepted (acc_stb for one cycle) once s2 has shown it for STABLE_CYC edges.
module cnt_sync_filter #(
    parameter int CW         = 3,
    parameter int STABLE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count_in,
    output logic [CW-1:0] acc_val,
    output logic          acc_stb
);

    logic [CW-1:0] s1_reg;
    logic [CW-1:0] s2_reg;
    logic [1:0]    vld_reg;
    logic [CW-1:0] cand_reg;
    logic [3:0]    run_reg;
    logic          same;

    assign same    = (s2_reg == cand_reg);
    assign acc_val = s2_reg;

    // vld_reg keeps the reset contents of s1/s2 from being counted as real samples.
    always_comb begin
        acc_stb = 1'b0;
        if (vld_reg[1]) begin
            if (same) begin
                acc_stb = (run_reg == 4'(STABLE_CYC - 1));
            end else begin
                acc_stb = (STABLE_CYC == 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            vld_reg  <= '0;
            cand_reg <= '0;
            run_reg  <= '0;
        end else begin
            s1_reg  <= count_in;
            s2_reg  <= s1_reg;
            vld_reg <= {vld_reg[0], 1'b1};
            if (vld_reg[1]) begin
                if (same) begin
                    // Saturating run length: a long-held value fires only once.
                    if (run_reg != 4'(STABLE_CYC)) begin
                        run_reg <= run_reg + 4'd1;
                    end
                end else begin
                    cand_reg <= s2_reg;
                    run_reg  <= 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mod_count_monitor.sv
// Monitor for a ripple-clocked mod-N counter: tracks the filtered count, produces a clean
// one-hot phase and wrap tick, counts wraps and flags illegal or out-of-sequence counts.
module mod_count_monitor
    import mod_mon_pkg::*;
#(
    parameter int MOD        = MOD_DEF,
    parameter int CW         = CW_DEF,
    parameter int STABLE_CYC = STABLE_DEF,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CW-1:0]     count_in,
    input  logic              clr_stat,
    output logic [MOD-1:0]    phase,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              locked,
    output logic              seq_err,
    output logic              illegal
);

    localparam int unsigned MOD_U = MOD;

    logic [CW-1:0]     acc_val;
    logic              acc_stb;
    logic [MOD-1:0]    val_onehot;
    logic              v_legal;
    logic              v_succ;
    logic              v_wrap;

    mon_state_t        state_reg,      state_next;
    logic [CW-1:0]     acc_reg,        acc_next;
    logic [MOD-1:0]    phase_reg,      phase_next;
    logic              wrap_pulse_reg, wrap_pulse_next;
    logic [WRAP_W-1:0] wrap_cnt_reg,   wrap_cnt_next;
    logic              seq_err_reg,    seq_err_next;
    logic              illegal_reg,    illegal_next;
    logic              seq_set;
    logic              ill_set;

    cnt_sync_filter #(
        .CW         (CW),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .acc_val  (acc_val),
        .acc_stb  (acc_stb)
    );

    for (genvar gi = 0; gi < MOD; gi++) begin : g_decode
        assign val_onehot[gi] = (acc_val == CW'(gi));
    end

    assign v_legal = (32'(acc_val) < MOD_U);
    assign v_succ  = (32'(acc_val) == next_count(32'(acc_reg), MOD_U));
    assign v_wrap  = (32'(acc_reg) == MOD_U - 1) && (acc_val == '0);

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        phase_next      = phase_reg;
        wrap_pulse_next = 1'b0;
        seq_set         = 1'b0;
        ill_set         = 1'b0;

        if (!en) begin
            state_next = IDLE;
            phase_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = ACQ;
                    phase_next = '0;
                end
                // Acquisition and fault recovery both take the next legal value unchecked.
                ACQ, FAULT: begin
                    if (acc_stb) begin
                        if (v_legal) begin
                            acc_next   = acc_val;
                            phase_next = val_onehot;
                            state_next = TRACK;
                        end else begin
                            ill_set    = 1'b1;
                            phase_next = '0;
                            state_next = FAULT;
                        end
                    end
                end
                TRACK: begin
                    if (acc_stb && (acc_val != acc_reg)) begin
                        if (!v_legal) begin
                            ill_set    = 1'b1;
                            phase_next = '0;
                            state_next = FAULT;
                        end else if (v_succ) begin
                            acc_next        = acc_val;
                            phase_next      = val_onehot;
                            wrap_pulse_next = v_wrap;
                        end else begin
                            seq_set    = 1'b1;
                            phase_next = '0;
                            state_next = FAULT;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    phase_next = '0;
                end
            endcase
        end

        // Clear first, then apply this cycle's events so a coincident event survives.
        wrap_cnt_next = clr_stat ? '0 : wrap_cnt_reg;
        if (wrap_pulse_next) begin
            wrap_cnt_next = wrap_cnt_next + WRAP_W'(1);
        end
        seq_err_next = (seq_err_reg & ~clr_stat) | seq_set;
        illegal_next = (illegal_reg & ~clr_stat) | ill_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            phase_reg      <= '0;
            wrap_pulse_reg <= 1'b0;
            wrap_cnt_reg   <= '0;
            seq_err_reg    <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            phase_reg      <= phase_next;
            wrap_pulse_reg <= wrap_pulse_next;
            wrap_cnt_reg   <= wrap_cnt_next;
            seq_err_reg    <= seq_err_next;
            illegal_reg    <= illegal_next;
        end
    end

    assign phase      = phase_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign wrap_cnt   = wrap_cnt_reg;
    assign locked     = (state_reg == TRACK);
    assign seq_err    = seq_err_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_mod_count_monitor.sv
// Bench for mod_count_monitor: directed scenarios plus random count streams, every cycle
// compared against a sample-history reference model of the monitor behaviour.
module tb_mod_count_monitor;

    localparam int MOD    = 5;
    localparam int CW     = 3;
    localparam int STABLE = 2;
    localparam int WRAP_W = 2;

    localparam int S_IDLE  = 0;
    localparam int S_ACQ   = 1;
    localparam int S_TRACK = 2;
    localparam int S_FAULT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [CW-1:0]     count_in = '0;
    logic              clr_stat = 1'b0;
    logic [MOD-1:0]    phase;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              locked;
    logic              seq_err;
    logic              illegal;

    mod_count_monitor #(
        .MOD        (MOD),
        .CW         (CW),
        .STABLE_CYC (STABLE),
        .WRAP_W     (WRAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count_in   (count_in),
        .clr_stat   (clr_stat),
        .phase      (phase),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .locked     (locked),
        .seq_err    (seq_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: samples of count_in since reset plus abstract monitor state.
    int hist[$];
    int m_state;
    int m_acc;
    int m_wp;
    int m_wc;
    int m_seq;
    int m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_state = S_IDLE;
        m_acc   = 0;
        m_wp    = 0;
        m_wc    = 0;
        m_seq   = 0;
        m_ill   = 0;
    endtask

    task automatic model_edge(input bit e, input bit clr, input int cin);
        int  idx;
        int  v;
        bit  stb;
        bit  set_seq;
        bit  set_ill;
        hist.push_back(cin);
        // The value visible after the two sync stages was sampled two edges ago; it is
        // accepted on the edge that completes a run of STABLE identical samples.
        idx = hist.size() - 3;
        stb = 1'b0;
        v   = 0;
        if (idx - (STABLE - 1) >= 0) begin
            v   = hist[idx];
            stb = 1'b1;
            for (int i = 1; i < STABLE; i++) begin
                if (hist[idx - i] != v) stb = 1'b0;
            end
            if (idx - STABLE >= 0 && hist[idx - STABLE] == v) stb = 1'b0;
        end
        set_seq = 1'b0;
        set_ill = 1'b0;
        m_wp    = 0;
        if (!e) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            m_state = S_ACQ;
        end else if (m_state == S_ACQ || m_state == S_FAULT) begin
            if (stb) begin
                if (v < MOD) begin
                    m_acc   = v;
                    m_state = S_TRACK;
                end else begin
                    set_ill = 1'b1;
                    m_state = S_FAULT;
                end
            end
        end else if (stb && v != m_acc) begin
            if (v >= MOD) begin
                set_ill = 1'b1;
                m_state = S_FAULT;
            end else if (v == (m_acc + 1) % MOD) begin
                if (m_acc == MOD - 1 && v == 0) m_wp = 1;
                m_acc = v;
            end else begin
                set_seq = 1'b1;
                m_state = S_FAULT;
            end
        end
        if (clr) begin
            m_wc  = 0;
            m_seq = 0;
            m_ill = 0;
        end
        if (m_wp != 0) m_wc = (m_wc + 1) % (1 << WRAP_W);
        if (set_seq) m_seq = 1;
        if (set_ill) m_ill = 1;
    endtask

    task automatic compare_all();
        int exp_phase;
        exp_phase = (m_state == S_TRACK) ? (1 << m_acc) : 0;
        check("phase", 32'(phase), exp_phase);
        check("wrap_pulse", 32'(wrap_pulse), m_wp);
        check("wrap_cnt", 32'(wrap_cnt), m_wc);
        check("locked", 32'(locked), (m_state == S_TRACK) ? 1 : 0);
        check("seq_err", 32'(seq_err), m_seq);
        check("illegal", 32'(illegal), m_ill);
    endtask

    task automatic step(input int c, input bit e, input bit cl);
        count_in = CW'(c);
        en       = e;
        clr_stat = cl;
        @(posedge clk);
        if (rst) model_edge(e, cl, c);
        else     model_reset();
        #1;
        compare_all();
    endtask

    task automatic hold(input int v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, 1'b1, 1'b0);
        $display("txn %-8s count_in=%0d cycles=%0d phase=%b locked=%0b wrap_cnt=%0d seq_err=%0b illegal=%0b",
                 tag, v, n, phase, locked, wrap_cnt, seq_err, illegal);
    endtask

    initial begin
        int exp_wc[4];
        int last;
        int v;
        int n;
        exp_wc = '{1, 2, 3, 0};
        model_reset();

        // Reset, then lock on 0 exactly at the 4th edge.
        repeat (3) step(0, 1'b0, 1'b0);
        check("rst_phase", 32'(phase), 0);
        check("rst_locked", 32'(locked), 0);
        rst = 1'b1;
        repeat (3) step(0, 1'b1, 1'b0);
        check("lock_edge3", 32'(locked), 0);
        step(0, 1'b1, 1'b0);
        check("lock_edge4", 32'(locked), 1);
        check("phase_edge4", 32'(phase), 1);
        hold(0, 2, "init");

        // Legal walk with one wrap.
        hold(1, 6, "seq");
        hold(2, 6, "seq");
        hold(3, 6, "seq");
        hold(4, 6, "seq");
        hold(0, 6, "seq");
        hold(1, 6, "seq");
        check("walk_wrap_cnt", 32'(wrap_cnt), 1);
        check("walk_seq_err", 32'(seq_err), 0);

        // One-sample glitch is filtered out.
        step(3, 1'b1, 1'b0);
        hold(1, 4, "glitch");
        hold(2, 6, "glitch");
        check("glitch_locked", 32'(locked), 1);
        check("glitch_seq_err", 32'(seq_err), 0);
        check("glitch_phase", 32'(phase), 32'h4);

        // Illegal value, recovery, then clear.
        hold(6, 6, "illegal");
        check("ill_flag", 32'(illegal), 1);
        check("ill_phase", 32'(phase), 0);
        hold(2, 6, "relock");
        check("relock_phase", 32'(phase), 32'h4);
        check("relock_ill", 32'(illegal), 1);
        step(2, 1'b1, 1'b1);
        check("clr_ill", 32'(illegal), 0);

        // Skip 1->3 then relock on 4 without a wrap.
        hold(3, 6, "seq");
        hold(4, 6, "seq");
        hold(0, 6, "seq");
        hold(1, 6, "seq");
        hold(3, 6, "skip");
        check("skip_seq_err", 32'(seq_err), 1);
        check("skip_locked", 32'(locked), 0);
        hold(4, 6, "relock");
        check("relock4_phase", 32'(phase), 32'h10);

        // wrap_cnt rollover in a 2-bit counter.
        step(4, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < MOD; k++) hold(k, 6, "roll");
            check("roll_wrap_cnt", 32'(wrap_cnt), exp_wc[r]);
        end

        // Clear on the same edge as a wrap keeps that wrap.
        repeat (3) step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        check("clr_wrap_cnt", 32'(wrap_cnt), 1);
        check("clr_wrap_pulse", 32'(wrap_pulse), 1);
        hold(0, 2, "clrwrap");

        // Disable drops lock but keeps statistics; re-enable reacquires on a new value.
        repeat (4) step(0, 1'b0, 1'b0);
        check("dis_locked", 32'(locked), 0);
        check("dis_wrap_cnt", 32'(wrap_cnt), 1);
        hold(1, 6, "reen");

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_wrap_cnt", 32'(wrap_cnt), 0);
        check("arst_phase", 32'(phase), 0);
        model_reset();
        repeat (2) step(2, 1'b1, 1'b0);
        rst = 1'b1;
        hold(2, 6, "postrst");

        // Randomised count streams.
        last = 2;
        for (int t = 0; t < 300; t++) begin
            v = ($urandom_range(0, 9) < 6) ? (last + 1) % MOD : int'($urandom_range(0, 7));
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                step(v, ($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0));
            end
            $display("txn rand     count_in=%0d cycles=%0d phase=%b locked=%0b wrap_cnt=%0d seq_err=%0b illegal=%0b",
                     v, n, phase, locked, wrap_cnt, seq_err, illegal);
            last = v;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
